// File: rtl/fsm_pkg.sv
// Shared types and constants for the serial pattern-detector tile.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fsm_pkg;

    localparam int PAT_W = 4;
    localparam logic [PAT_W-1:0] DEFAULT_PATTERN = 4'b1011;

    // Number of pattern bits currently matched; S4 means a full match.
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    // Codes 5..7 are unreachable in normal operation and must recover to S0.
    function automatic logic is_legal(input state_t s);
        return (s <= S4);
    endfunction

endpackage

// File: rtl/fsm_next_state.sv
// Combinational next-state for the prefix-length FSM: longest pattern prefix that is a suffix of the input.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the bit is consumed. Optional macro: FSM_OVERLAP_EN.
import fsm_pkg::*;

module fsm_next_state (
    input  state_t             state,
    input  logic [PAT_W-1:0]   history,
    input  logic               b,
    input  logic [PAT_W-1:0]   pattern,
    output state_t             next
);

    logic [PAT_W-1:0] window;
    logic             m1;
    logic             m2;
    logic             m3;
    logic             m4;
    logic [2:0]       limit;

    // Newest bit sits in window[0]; the oldest of the last four in window[3].
    assign window = {history[2:0], b};

    // Last j bits (oldest first) against the first j pattern bits.
    assign m1 = (window[0]   == pattern[3]);
    assign m2 = (window[1:0] == pattern[3:2]);
    assign m3 = (window[2:0] == pattern[3:1]);
    assign m4 = (window      == pattern);

    // Longest match is bounded by what the current state guarantees is valid history.
    always_comb begin
        limit = 3'd0;
        case (state)
            S0: limit = 3'd1;
            S1: limit = 3'd2;
            S2: limit = 3'd3;
            S3: limit = 3'd4;
`ifdef FSM_OVERLAP_EN
            S4: limit = 3'd4;
`else
            S4: limit = 3'd1;
`endif
            default: limit = 3'd0;
        endcase
    end

    // Pick the largest admissible prefix length that matches.
    always_comb begin
        next = S0;
        if (limit >= 3'd4 && m4) begin
            next = S4;
        end else if (limit >= 3'd3 && m3) begin
            next = S3;
        end else if (limit >= 3'd2 && m2) begin
            next = S2;
        end else if (limit >= 3'd1 && m1) begin
            next = S1;
        end
    end

endmodule

// File: rtl/tt_um_fsm_dgarciag44.sv
// Tiny Tapeout tile: programmable 4-bit serial sequence detector with match pulse and wrap-around match counter.
// Latency: match/count visible one cycle after the edge sampling the last pattern bit.
// Backpressure: none; din_valid=0 or ena=0 simply holds state. Optional macro: FSM_OVERLAP_EN.
import fsm_pkg::*;

module tt_um_fsm_dgarciag44 (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic             rst;
    logic             din;
    logic             din_valid;
    logic             load;
    logic [PAT_W-1:0] pat_in;
    logic             clr_cnt;
    logic             consume;

    state_t           state;
    state_t           nxt;
    logic [PAT_W-1:0] pattern;
    logic [PAT_W-1:0] history;
    logic [3:0]       count;
    logic             match;
    logic             hit;
    logic             unused_ok;

    assign rst       = !rst_n;
    assign din       = ui_in[0];
    assign din_valid = ui_in[1];
    assign load      = ui_in[2];
    assign pat_in    = ui_in[6:3];
    assign clr_cnt   = ui_in[7];

    // A load cycle discards the serial sample.
    assign consume = ena && din_valid && !load;
    assign hit     = consume && (nxt == S4);

    fsm_next_state u_next (
        .state   (state),
        .history (history),
        .b       (din),
        .pattern (pattern),
        .next    (nxt)
    );

    // All tile state: FSM, pattern, history, match pulse and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S0;
            pattern <= DEFAULT_PATTERN;
            history <= '0;
            count   <= '0;
            match   <= 1'b0;
        end else begin
            if (!is_legal(state)) begin
                state <= S0;
            end
            if (ena) begin
                if (load) begin
                    pattern <= pat_in;
                    state   <= S0;
                    history <= '0;
                    match   <= 1'b0;
                end else if (din_valid) begin
                    history <= {history[2:0], din};
                    state   <= nxt;
                    match   <= (nxt == S4);
                end else begin
                    match   <= 1'b0;
                end
                // Clear takes priority over a same-cycle increment.
                if (clr_cnt) begin
                    count <= '0;
                end else if (hit) begin
                    count <= count + 4'd1;
                end
            end
        end
    end

    assign uo_out    = {count, state, match};
    assign uio_out   = 8'h00;
    assign uio_oe    = 8'h00;
    assign unused_ok = &{1'b0, uio_in};

endmodule

// File: tb/tb_tt_um_fsm_dgarciag44.sv
// Self-checking bench: directed scenarios plus random traffic against a suffix/prefix reference model.
// Latency: checks uo_out 1 time unit after each rising edge.
// Backpressure: exercises din_valid gaps, ena freezes, loads, clears and resets.
module tb_tt_um_fsm_dgarciag44;

`ifdef FSM_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad   = 0;

    // Reference model: recent consumed bits (oldest first), pattern, outputs.
    bit         q[$];
    logic [3:0] m_pat;
    int         m_state;
    int         m_cnt;
    bit         m_match;

    always #5 clk = ~clk;

    tt_um_fsm_dgarciag44 dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [3:0] c;
        logic [2:0] s;
        c = m_cnt[3:0];
        s = m_state[2:0];
        return {c, s, m_match};
    endfunction

    // Longest suffix of the consumed stream equal to a prefix of the pattern.
    function automatic int longest();
        int best = 0;
        for (int j = 1; j <= 4 && j <= q.size(); j++) begin
            bit ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (q[q.size() - j + i] != m_pat[3 - i]) ok = 1'b0;
            end
            if (ok) best = j;
        end
        return best;
    endfunction

    task automatic model_step(input bit rst, input bit e, input bit din, input bit vld,
                              input bit ld, input logic [3:0] p, input bit clr);
        if (rst) begin
            q.delete();
            m_pat   = 4'b1011;
            m_state = 0;
            m_cnt   = 0;
            m_match = 1'b0;
        end else if (e) begin
            if (ld) begin
                m_pat   = p;
                q.delete();
                m_state = 0;
                m_match = 1'b0;
            end else if (vld) begin
                q.push_back(din);
                if (q.size() > 4) void'(q.pop_front());
                m_state = longest();
                m_match = (m_state == 4);
                if (m_match) begin
                    m_cnt = (m_cnt + 1) % 16;
                    // Without overlap, bits before a match never count again.
                    if (!OVL) q.delete();
                end
            end else begin
                m_match = 1'b0;
            end
            if (clr) m_cnt = 0;
        end
    endtask

    task automatic cyc(input bit rst, input bit e, input bit din, input bit vld,
                       input bit ld, input logic [3:0] p, input bit clr, input string tag);
        rst_n = !rst;
        ena   = e;
        ui_in = {clr, p, ld, vld, din};
        model_step(rst, e, din, vld, ld, p, clr);
        @(posedge clk);
        #1;
        check(tag, uo_out, model_out());
    endtask

    task automatic bit_in(input bit b, input string tag);
        cyc(1'b0, 1'b1, b, 1'b1, 1'b0, 4'h0, 1'b0, tag);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "reset");
    endtask

    initial begin
        logic [3:0] seq;
        uio_in = 8'h00;

        // Reset state.
        do_reset();
        do_reset();
        check("reset_uo", uo_out, 8'h00);
        check("uio_out", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'h00);

        // Basic detection of 1011.
        bit_in(1'b1, "t1_b0");
        check("t1_s1", uo_out, 8'h02);
        bit_in(1'b0, "t1_b1");
        bit_in(1'b1, "t1_b2");
        bit_in(1'b1, "t1_b3");
        check("t1_match", uo_out, 8'h19);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "t1_idle");
        check("t1_pulse_end", uo_out, 8'h18);

        // Overlap behaviour on 1011011.
        do_reset();
        seq = 4'b1011;
        for (int i = 0; i < 4; i++) bit_in(seq[3 - i], "t2_a");
        seq = 4'b0110;
        for (int i = 0; i < 3; i++) bit_in(seq[3 - i], "t2_b");
        check("t2_count", {4'h0, uo_out[7:4]}, OVL ? 8'd2 : 8'd1);

        // Pattern 0000 with six zeros.
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, "t3_load");
        for (int i = 0; i < 6; i++) bit_in(1'b0, "t3_bit");
        check("t3_count", {4'h0, uo_out[7:4]}, OVL ? 8'd3 : 8'd1);

        // Gaps and enable freezes inside 1011.
        do_reset();
        bit_in(1'b1, "t4_b0");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "t4_gap");
        check("t4_hold", uo_out, 8'h02);
        bit_in(1'b0, "t4_b1");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, "t4_ena0");
        check("t4_frozen", uo_out, 8'h04);
        bit_in(1'b1, "t4_b2");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "t4_gap2");
        bit_in(1'b1, "t4_b3");
        check("t4_match", uo_out, 8'h19);

        // Clear on the same cycle as the final bit.
        do_reset();
        bit_in(1'b1, "t5_b0");
        bit_in(1'b0, "t5_b1");
        bit_in(1'b1, "t5_b2");
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, "t5_b3_clr");
        check("t5_clr_wins", uo_out, 8'h09);

        // Sixteen matches wrap the counter.
        do_reset();
        seq = 4'b1011;
        for (int m = 0; m < 16; m++) begin
            for (int i = 0; i < 4; i++) bit_in(seq[3 - i], "t6_bit");
            if (m == 14) check("t6_count15", {4'h0, uo_out[7:4]}, 8'd15);
        end
        check("t6_wrap", uo_out, 8'h09);

        // Reset mid-pattern restores default pattern.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, "t7_load");
        bit_in(1'b0, "t7_b0");
        bit_in(1'b0, "t7_b1");
        do_reset();
        check("t7_reset", uo_out, 8'h00);
        for (int i = 0; i < 4; i++) bit_in(seq[3 - i], "t7_bit");
        check("t7_default_pat", uo_out, 8'h19);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            bit         r_rst;
            bit         r_ena;
            bit         r_vld;
            bit         r_ld;
            bit         r_clr;
            bit         r_din;
            logic [3:0] r_pat;
            r_rst = ($urandom_range(0, 99) < 1);
            r_ena = ($urandom_range(0, 99) < 90);
            r_vld = ($urandom_range(0, 99) < 75);
            r_ld  = ($urandom_range(0, 99) < 3);
            r_clr = ($urandom_range(0, 99) < 3);
            r_din = 1'($urandom_range(0, 1));
            r_pat = 4'($urandom_range(0, 15));
            cyc(r_rst, r_ena, r_din, r_vld, r_ld, r_pat, r_clr, "random");
        end

        check("uio_out_end", uio_out, 8'h00);
        check("uio_oe_end", uio_oe, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_um_fsm_dgarciag44.md
Name: tt_um_fsm_dgarciag44

Overview:
- Tiny Tapeout user tile: serial bit-stream sequence detector built around a prefix-length FSM.
- Detects a programmable 4-bit pattern on a qualified serial input and pulses a match flag.
- Keeps a 4-bit match counter and exposes the FSM state on the dedicated outputs.
- Sits directly under the TT harness; all I/O uses the standard TT pin set.

Parameters:
- DEFAULT_PATTERN, 4'b1011, pattern loaded at reset. MSB is the first bit expected on the serial input.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  TT harness reset pin. One clock; reset is synchronous and active-high: internal rst = !rst_n, sampled on the rising edge of clk.
- ena  input  1  tile enable; 0 freezes all registers (reset still applies).
- ui_in  input  8  [0]=din, [1]=din_valid, [2]=load, [6:3]=pattern value, [7]=clr_cnt.
- uo_out  output  8  [0]=match pulse, [3:1]=FSM state (0..4), [7:4]=match count.
- uio_in  input  8  unused.
- uio_out  output  8  constant 8'h00.
- uio_oe  output  8  constant 8'h00 (all bidirectionals are inputs).

Behaviour:
- Reset: state=S0, pattern=DEFAULT_PATTERN, count=0, match=0, history=0. All uo_out bits are 0 after reset.
- States S0..S4 encode the number of pattern bits currently matched; S4 means MATCH. Encoding is 3'd0..3'd4; codes 5..7 are illegal and recover to S0 on the next clock.
- A bit is consumed only when ena=1, din_valid=1 and load=0. When no bit is consumed, state and history hold.
- On a consumed bit b: history <= {history[2:0], b}.
- Next state from Sk (k<4) = largest j <= k+1 such that the last j consumed bits, including b, equal pattern[3:4-j]. If no such j exists, next state is S0.
- From S4: candidate set depends on FSM_OVERLAP_EN (see Optional Feature).
- match register: 1 for exactly one cycle after the edge that transitions the state into S4, else 0. Re-entering S4 from S4 (overlap) also pulses match.
- count: increments on the same edge that sets match. Wraps 15 -> 0.
- load=1 (with ena=1): pattern <= ui_in[6:3], state <= S0, history <= 0. The din sample in that cycle is discarded. The count is untouched.
- clr_cnt=1 (with ena=1): count <= 0. Clear wins over a simultaneous increment; match still pulses.
- Latency: match and count update are registered, visible one cycle after the clock edge that samples the final pattern bit.
- Reset asserted mid-stream returns to the reset values on the next edge, including pattern=DEFAULT_PATTERN.

Optional Feature:
- Macro FSM_OVERLAP_EN.
- Defined: from S4, j ranges up to 4 using the full history, so overlapping occurrences are all detected.
- Undefined: from S4, the next state is computed as if from S0 (j <= 1), so matches are non-overlapping.

Decomposition:
- Package fsm_pkg holds:
  - state typedef (3-bit enum S0..S4),
  - PAT_W=4,
  - the DEFAULT_PATTERN constant value.
- One sub-module, fsm_next_state. It is purely combinational: (state, history, b, pattern) -> next state, and contains the prefix/suffix compare logic and the FSM_OVERLAP_EN selection.
- The top level holds all registers, the counter and the pin mapping.

Test Plan:
- Reset, then consume bits 1,0,1,1: state reads 1,0→? per bit = 1,2,3,4. match=1 for one cycle after the 4th edge; uo_out[7:4]=1.
- Bits 1,0,1,1,0,1,1: count=2 with FSM_OVERLAP_EN; count=1 without it.
- Load pattern 4'b0000, then consume six 0s: count=3 with overlap; count=1 without.
- Insert din_valid=0 gaps and ena=0 cycles inside 1,0,1,1: detection is unaffected, state holds during the gaps, and one match occurs.
- Assert clr_cnt on the same cycle as the 4th bit of a match: match pulses, count=0.
- 16 matches in a row: count wraps to 0. rst_n=0 mid-pattern: state=0, count=0, pattern reverts to 1011.
